// File: rtl/display_pkg.sv
// Shared scan-state encoding and segment constants for the display scan controller.
package display_pkg;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

endpackage

// File: rtl/display_decoder.sv
// 4-bit to active-low 7-segment decoder, segment order g..a = [6:0].
// Values 10-15 render the "E" error glyph.
module display_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_ERR;
        case (nibble)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode display scanner with shadowed value and frame-aligned commit.
//   state    | meaning
//   ST_SCAN  | digit idx lit for DWELL_CYCLES clocks
//   ST_GUARD | all digits dark for GUARD_CYCLES clocks, then advance idx
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_sync
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shown_q, shown_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    load_ready_q, load_ready_d;
    logic [6:0]              seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_sync_q, frame_sync_d;

    logic [3:0] dec_nibble;
    logic [6:0] dec_seg;
    logic       wrap;
    logic       lit;

    assign dec_nibble = shown_q[{idx_q, 2'b00} +: 4];

    display_decoder u_decoder (
        .nibble (dec_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shown_d      = shown_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_sync_d = 1'b0;
        wrap         = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
        endcase

        // Only a value already pending commits here; an accept this cycle waits a frame.
        if (wrap) begin
            frame_sync_d = 1'b1;
            if (pending_q) begin
                shown_d   = shadow_q;
                pending_d = 1'b0;
            end
        end

        if (load_valid && load_ready_q) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        load_ready_d = ~pending_d;

        lit        = (state_q == ST_SCAN) && !blank_mask[idx_q];
        seg_out_d  = SEG_BLANK;
        digit_en_d = '1;
        if (lit) begin
            seg_out_d         = dec_seg;
            digit_en_d[idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SCAN;
            idx_q        <= '0;
            cnt_q        <= '0;
            shown_q      <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            load_ready_q <= 1'b0;
            seg_out_q    <= SEG_BLANK;
            digit_en_q   <= '1;
            frame_sync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shown_q      <= shown_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            seg_out_q    <= seg_out_d;
            digit_en_q   <= digit_en_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    assign load_ready = load_ready_q;
    assign seg_out    = seg_out_q;
    assign digit_en   = digit_en_q;
    assign frame_sync = frame_sync_q;

endmodule
